// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_pkg
// Description : Shared types, widths and prescaler helpers for the SPI SCLK engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_CNT_W = 11;
    localparam int c_LEN_W = 5;
    localparam int c_DIV_W = 12;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SETUP = 2'd1;
    localparam state_t c_ST_RUN   = 2'd2;
    localparam state_t c_ST_HOLD  = 2'd3;

    // Mode is {cpol, cpha}
    typedef logic [1:0] spi_mode_t;
    localparam spi_mode_t c_MODE0 = 2'b00;

    function automatic logic mode_cpol(input spi_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_t mode);
        return mode[0];
    endfunction

    function automatic logic [c_CNT_W-1:0] half_period(input logic [2:0] sppr, input logic [2:0] spr);
        logic [c_CNT_W-1:0] w_base;
        w_base = c_CNT_W'(sppr) + c_CNT_W'(1);
        return w_base << spr;
    endfunction

    function automatic logic [c_DIV_W-1:0] divisor(input logic [2:0] sppr, input logic [2:0] spr);
        logic [c_DIV_W-1:0] w_base;
        w_base = c_DIV_W'(sppr) + c_DIV_W'(1);
        return w_base << ({1'b0, spr} + 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_engine_if.sv
`default_nettype none
// ============================================================================
// Interface   : spi_sclk_engine_if
// Description : Control, configuration and timing outputs of the SCLK engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_sclk_engine_if #(
    parameter int LEN_W = 5
);
    logic             start_i;
    logic             abort_i;
    logic             spiswai_i;
    logic             cpol_i;
    logic             cpha_i;
    logic [2:0]       sppr_i;
    logic [2:0]       spr_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             sclk_o;
    logic             shift_o;
    logic             sample_o;
    logic [LEN_W-1:0] bit_idx_o;
    logic             busy_o;
    logic             done_o;
    logic [11:0]      divisor_o;

    modport master (
        output start_i, abort_i, spiswai_i, cpol_i, cpha_i, sppr_i, spr_i, frame_len_i,
        input  sclk_o, shift_o, sample_o, bit_idx_o, busy_o, done_o, divisor_o
    );

    modport slave (
        input  start_i, abort_i, spiswai_i, cpol_i, cpha_i, sppr_i, spr_i, frame_len_i,
        output sclk_o, shift_o, sample_o, bit_idx_o, busy_o, done_o, divisor_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_half_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_half_period_counter
// Description : Free-running 0..H-1 counter with loadable H, freeze and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_half_period_counter #(
    parameter int CNT_W = 11
) (
    input  wire logic             PCLK,
    input  wire logic             PRESET_n,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] half_period_i,
    input  wire logic             clear_i,
    input  wire logic             enable_i,
    output logic                  tick_o
);
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    assign w_tick = (r_count == (r_half - CNT_W'(1)));
    assign tick_o = w_tick;

    always_ff @(posedge PCLK) begin
        if (!PRESET_n) begin
            r_half  <= CNT_W'(1);
            r_count <= '0;
        end else begin
            if (load_i) begin
                r_half <= half_period_i;
            end
            if (clear_i) begin
                r_count <= '0;
            end else if (enable_i) begin
                r_count <= w_tick ? '0 : r_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_sclk_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_engine
// Description : SPI serial clock and frame timing with per-bit shift/sample strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int CNT_W = c_CNT_W,
    parameter int LEN_W = c_LEN_W
) (
    input  wire logic        PCLK,
    input  wire logic        PRESET_n,
    spi_sclk_engine_if.slave bus
);
    localparam int c_EDGE_W = LEN_W + 2;

    state_t              r_state;
    state_t              w_state_nxt;
    spi_mode_t           r_mode;
    logic [LEN_W-1:0]    r_last_idx;
    logic [c_EDGE_W-1:0] r_last_edge;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic [c_EDGE_W-1:0] w_edge_cnt_nxt;
    logic [c_EDGE_W-1:0] w_edge_inc;
    logic                r_sclk;
    logic                w_sclk_nxt;
    logic                r_shift;
    logic                w_shift_nxt;
    logic                r_sample;
    logic                w_sample_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_done_nxt;
    logic [LEN_W-1:0]    r_bit_idx;
    logic                r_idx_pend;
    logic [CNT_W-1:0]    w_half_live;
    logic                w_tick;
    logic                w_advance;
    logic                w_start_acc;
    logic                w_abort;
    logic                w_leading;
    logic                w_final;
    logic                w_cnt_clear;
    logic                w_cnt_en;

    assign w_half_live = CNT_W'(half_period(bus.sppr_i, bus.spr_i));
    assign w_start_acc = (r_state == c_ST_IDLE) && bus.start_i;
    assign w_abort     = (r_state != c_ST_IDLE) && bus.abort_i;
    assign w_advance   = w_tick && !bus.spiswai_i;
    assign w_cnt_clear = (r_state == c_ST_IDLE) || w_abort;
    assign w_cnt_en    = (r_state != c_ST_IDLE) && !bus.spiswai_i;
    assign w_edge_inc  = r_edge_cnt + c_EDGE_W'(1);
    assign w_leading   = w_edge_inc[0];
    assign w_final     = (w_edge_inc == r_last_edge);

    spi_half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .PCLK          (PCLK),
        .PRESET_n      (PRESET_n),
        .load_i        (w_start_acc),
        .half_period_i (w_half_live),
        .clear_i       (w_cnt_clear),
        .enable_i      (w_cnt_en),
        .tick_o        (w_tick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_cnt_nxt = r_edge_cnt;
        w_sclk_nxt     = r_sclk;
        w_shift_nxt    = 1'b0;
        w_sample_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_sclk_nxt     = bus.cpol_i;
                w_edge_cnt_nxt = '0;
                if (bus.start_i) begin
                    w_state_nxt = c_ST_SETUP;
                    // CPHA=0 presents bit 0 before the first edge
                    w_shift_nxt = !bus.cpha_i;
                end
            end
            c_ST_SETUP, c_ST_RUN: begin
                if (w_advance) begin
                    w_state_nxt    = w_final ? c_ST_HOLD : c_ST_RUN;
                    w_sclk_nxt     = !r_sclk;
                    w_edge_cnt_nxt = w_edge_inc;
                    if (mode_cpha(r_mode)) begin
                        w_shift_nxt  = w_leading;
                        w_sample_nxt = !w_leading;
                    end else begin
                        w_sample_nxt = w_leading;
                        w_shift_nxt  = !w_leading && !w_final;
                    end
                end
            end
            c_ST_HOLD: begin
                if (w_advance) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt    = c_ST_IDLE;
            w_edge_cnt_nxt = '0;
            w_sclk_nxt     = bus.cpol_i;
            w_shift_nxt    = 1'b0;
            w_sample_nxt   = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET_n) begin
            r_state     <= c_ST_IDLE;
            r_mode      <= c_MODE0;
            r_last_idx  <= '0;
            r_last_edge <= '0;
            r_edge_cnt  <= '0;
            r_sclk      <= bus.cpol_i;
            r_shift     <= 1'b0;
            r_sample    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bit_idx   <= '0;
            r_idx_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sclk     <= w_sclk_nxt;
            r_shift    <= w_shift_nxt;
            r_sample   <= w_sample_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= (w_state_nxt != c_ST_IDLE);
            if (w_start_acc) begin
                r_mode      <= {bus.cpol_i, bus.cpha_i};
                r_last_idx  <= bus.frame_len_i;
                r_last_edge <= c_EDGE_W'({bus.frame_len_i, 1'b1}) + c_EDGE_W'(1);
            end
            // A sample seen just before a freeze still advances the index on resume
            if (w_state_nxt == c_ST_IDLE) begin
                r_bit_idx  <= '0;
                r_idx_pend <= 1'b0;
            end else if (bus.spiswai_i) begin
                r_idx_pend <= r_idx_pend | r_sample;
            end else begin
                r_idx_pend <= 1'b0;
                if ((r_sample || r_idx_pend) && (r_bit_idx != r_last_idx)) begin
                    r_bit_idx <= r_bit_idx + LEN_W'(1);
                end
            end
        end
    end

    assign bus.sclk_o    = r_sclk;
    assign bus.shift_o   = r_shift;
    assign bus.sample_o  = r_sample;
    assign bus.bit_idx_o = r_bit_idx;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.divisor_o = divisor(bus.sppr_i, bus.spr_i);

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sclk_engine
// Description : Self-checking bench for spi_sclk_engine using a per-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sclk_engine;

    logic PCLK;
    logic PRESET_n;

    spi_sclk_engine_if #(.LEN_W(5)) bus ();

    spi_sclk_engine #(
        .CNT_W (11),
        .LEN_W (5)
    ) dut (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .bus      (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       sclk;
        logic       shift;
        logic       sample;
        logic [4:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    function automatic exp_t observed();
        exp_t o;
        o.busy   = bus.busy_o;
        o.done   = bus.done_o;
        o.sclk   = bus.sclk_o;
        o.shift  = bus.shift_o;
        o.sample = bus.sample_o;
        o.idx    = bus.bit_idx_o;
        return o;
    endfunction

    // Reference timeline of one frame: cycle k=1 is the first busy cycle,
    // edge e (1..2N) lands on cycle 1+e*H, followed by the done cycle.
    task automatic push_frame(input logic cpol, input logic cpha, input int h, input int n);
        exp_t e;
        int   samples;
        int   eidx;
        bit   at_edge;
        samples = 0;
        for (int k = 1; k <= (2 * n + 1) * h; k++) begin
            eidx    = (k - 1) / h;
            at_edge = ((k - 1) % h == 0) && (eidx >= 1);
            e        = '0;
            e.busy   = 1'b1;
            e.sclk   = cpol ^ (eidx % 2 == 1);
            e.idx    = 5'((samples > n - 1) ? n - 1 : samples);
            if (k == 1 && !cpha) e.shift = 1'b1;
            if (at_edge) begin
                if (eidx % 2 == 1) begin
                    if (cpha) e.shift = 1'b1; else e.sample = 1'b1;
                end else begin
                    if (cpha) e.sample = 1'b1;
                    else if (eidx < 2 * n) e.shift = 1'b1;
                end
            end
            if (e.sample) samples++;
            exp_q.push_back(e);
        end
        e      = '0;
        e.done = 1'b1;
        e.sclk = cpol;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input logic cpol);
        exp_t e;
        e      = '0;
        e.sclk = cpol;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic cpol, input logic cpha, input logic [2:0] sppr,
                           input logic [2:0] spr, input logic [4:0] len);
        bus.cpol_i      = cpol;
        bus.cpha_i      = cpha;
        bus.sppr_i      = sppr;
        bus.spr_i       = spr;
        bus.frame_len_i = len;
    endtask

    task automatic test_reset();
        exp_t o;
        exp_t e;
        PRESET_n = 1'b0;
        set_cfg(1'b1, 1'b0, 3'd0, 3'd0, 5'd0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        o = observed();
        e = '0;
        e.sclk = 1'b1;
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b (busy,done,sclk,shift,sample,idx)", o, e);
        end
        PRESET_n = 1'b1;
        @(negedge PCLK);
        bus.cpol_i = 1'b0;
        #1;
        n_checks++;
        if (bus.sclk_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sclk_registered: got %b required 1", bus.sclk_o);
        end
        @(negedge PCLK);
        n_checks++;
        if (bus.sclk_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cpol_follow: got %b required 0", bus.sclk_o);
        end
    endtask

    task automatic test_divisor();
        logic [2:0] sp_tab [5];
        logic [2:0] s_tab  [5];
        int         expv;
        sp_tab = '{3'd0, 3'd7, 3'd2, 3'd5, 3'd3};
        s_tab  = '{3'd0, 3'd7, 3'd1, 3'd3, 3'd6};
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            bus.sppr_i = sp_tab[i];
            bus.spr_i  = s_tab[i];
            #1;
            expv = (int'(sp_tab[i]) + 1) * (2 ** (int'(s_tab[i]) + 1));
            n_checks++;
            if (int'(bus.divisor_o) !== expv) begin
                n_fail++;
                $display("FAIL divisor_%0d: got %0d required %0d", i, bus.divisor_o, expv);
            end
        end
    endtask

    task automatic test_mode0();
        exp_t o;
        exp_t e;
        int   c;
        int   n_sh;
        int   n_sa;
        int   n_bz;
        int   n_dn;
        n_sh = 0; n_sa = 0; n_bz = 0; n_dn = 0; c = 0;
        @(negedge PCLK);
        set_cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd7);
        push_frame(1'b0, 1'b0, 1, 8);
        push_idle(1'b0);
        bus.start_i = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            bus.start_i = 1'b0;
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode0 cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            n_sh += int'(o.shift); n_sa += int'(o.sample);
            n_bz += int'(o.busy);  n_dn += int'(o.done);
            c++;
        end
        n_checks++;
        if (n_sh !== 8 || n_sa !== 8) begin
            n_fail++;
            $display("FAIL mode0_strobe_count: got shift=%0d sample=%0d required 8/8", n_sh, n_sa);
        end
        n_checks++;
        if (n_bz !== 17 || n_dn !== 1) begin
            n_fail++;
            $display("FAIL mode0_busy_done: got busy=%0d done=%0d required 17/1", n_bz, n_dn);
        end
    endtask

    task automatic test_mode3();
        exp_t o;
        exp_t e;
        int   c;
        int   n_bz;
        int   last_idx;
        n_bz = 0; c = 0; last_idx = -1;
        @(negedge PCLK);
        set_cfg(1'b1, 1'b1, 3'd2, 3'd1, 5'd15);
        #1;
        n_checks++;
        if (bus.divisor_o !== 12'd12) begin
            n_fail++;
            $display("FAIL mode3_divisor: got %0d required 12", bus.divisor_o);
        end
        push_frame(1'b1, 1'b1, 6, 16);
        push_idle(1'b1);
        bus.start_i = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            bus.start_i = 1'b0;
            if (c == 20) begin
                bus.sppr_i = 3'd7; bus.cpha_i = 1'b0; bus.frame_len_i = 5'd3;
            end
            if (c == 100) set_cfg(1'b1, 1'b1, 3'd2, 3'd1, 5'd15);
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mode3 cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            n_bz += int'(o.busy);
            if (o.busy) last_idx = int'(o.idx);
            c++;
        end
        n_checks++;
        if (n_bz !== 198 || last_idx !== 15) begin
            n_fail++;
            $display("FAIL mode3_busy_idx: got busy=%0d idx=%0d required 198/15", n_bz, last_idx);
        end
    endtask

    task automatic test_freeze();
        exp_t o;
        exp_t e;
        exp_t f;
        int   c;
        int   n_bz;
        int   p;
        int   nf;
        p = 9; nf = 10; n_bz = 0; c = 0;
        @(negedge PCLK);
        set_cfg(1'b0, 1'b1, 3'd1, 3'd0, 5'd7);
        push_frame(1'b0, 1'b1, 2, 8);
        f = exp_q[p];
        f.shift  = 1'b0;
        f.sample = 1'b0;
        for (int i = 0; i < nf; i++) exp_q.insert(p + 1, f);
        push_idle(1'b0);
        bus.start_i   = 1'b1;
        bus.spiswai_i = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            bus.start_i   = 1'b0;
            bus.spiswai_i = (c >= p) && (c < p + nf);
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL freeze cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            n_bz += int'(o.busy);
            c++;
        end
        bus.spiswai_i = 1'b0;
        n_checks++;
        if (n_bz !== 44) begin
            n_fail++;
            $display("FAIL freeze_busy_len: got %0d required 44", n_bz);
        end
    endtask

    task automatic test_abort();
        exp_t o;
        exp_t e;
        int   c;
        int   a;
        int   ns;
        int   n_dn;
        @(negedge PCLK);
        set_cfg(1'b1, 1'b0, 3'd1, 3'd0, 5'd7);
        push_frame(1'b1, 1'b0, 2, 8);
        a = -1; ns = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].sample) begin
                ns++;
                if (ns == 3 && a < 0) a = i;
            end
        end
        while (exp_q.size() > a + 1) void'(exp_q.pop_back());
        push_idle(1'b1);
        push_idle(1'b1);
        bus.start_i = 1'b1;
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            bus.start_i   = 1'b0;
            bus.abort_i   = (c == a);
            bus.spiswai_i = (c == a);
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            c++;
        end
        bus.abort_i   = 1'b0;
        bus.spiswai_i = 1'b0;
        push_frame(1'b1, 1'b0, 2, 8);
        push_idle(1'b1);
        bus.start_i = 1'b1;
        c = 0; n_dn = 0;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            bus.start_i = 1'b0;
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL post_abort cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            n_dn += int'(o.done);
            c++;
        end
        n_checks++;
        if (n_dn !== 1) begin
            n_fail++;
            $display("FAIL post_abort_done: got %0d required 1", n_dn);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o;
        exp_t e;
        int   c;
        int   n_dn;
        @(negedge PCLK);
        set_cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd3);
        push_frame(1'b0, 1'b0, 1, 4);
        push_frame(1'b0, 1'b0, 1, 4);
        push_idle(1'b0);
        bus.start_i = 1'b1;
        c = 0; n_dn = 0;
        while (exp_q.size() > 0) begin
            @(negedge PCLK);
            if (c == 19) bus.start_i = 1'b0;
            o = observed();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b required %b (busy,done,sclk,shift,sample,idx)", c, o, e);
            end
            n_dn += int'(o.done);
            c++;
        end
        bus.start_i = 1'b0;
        n_checks++;
        if (n_dn !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d required 2", n_dn);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.spiswai_i = 1'b0;
        test_reset();
        test_divisor();
        test_mode0();
        test_mode3();
        test_freeze();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Parametrised SPI serial-clock and frame-timing engine, successor to the fixed baud generator in the SPI master datapath. Derives the SCLK half-period from the SPPR/SPR prescaler fields, runs a complete frame of configurable length in any of the four CPOL/CPHA modes, and issues exactly one shift strobe and one sample strobe per bit to the shift register. It adds setup/hold half-periods, start/busy/done handshaking, wait-mode freeze and abort.

## Interface
- CNT_W, 11: half-period counter width; must hold the maximum half-period of 1024.
- LEN_W, 5: frame-length field width; the maximum frame is 2^LEN_W bits.
- PCLK  in  1  APB clock; the only clock.
- PRESET_n  in  1  reset; synchronous, active-low.
- start_i  in  1  frame request; accepted only in IDLE.
- abort_i  in  1  terminate the frame; return to IDLE.
- spiswai_i  in  1  wait-mode freeze.
- cpol_i, cpha_i  in  1 each  clock mode.
- sppr_i, spr_i  in  3 each  prescaler fields.
- frame_len_i  in  LEN_W  number of bits minus 1.
- sclk_o  out  1  serial clock.
- shift_o  out  1  one-cycle strobe: drive the next MOSI bit.
- sample_o  out  1  one-cycle strobe: capture MISO.
- bit_idx_o  out  LEN_W  index of the current bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at normal frame completion.
- divisor_o  out  12  (sppr+1)·2^(spr+1), computed from live inputs.

## Operation
- Half-period H = (sppr+1) << spr, range 1..1024. Compute it at full width with no truncation; H=1 is legal.
- FSM states: IDLE, SETUP, RUN, HOLD.
- IDLE:
  - sclk_o is registered from cpol_i each cycle.
  - Counters are zero.
  - start_i latches cpol, cpha, H and N=frame_len_i+1, then the FSM enters SETUP.
- SETUP: H cycles with sclk_o at idle level, then RUN.
- RUN:
  - sclk_o toggles every H cycles, 2N edges in total.
  - The leading edge is the transition away from CPOL.
- Strobe rules:
  - CPHA=0: sample_o on leading edges. shift_o on trailing edges, except the final trailing edge. shift_o also pulses in the first SETUP cycle to present bit 0.
  - CPHA=1: shift_o on leading edges, sample_o on trailing edges.
  - Net result in all modes: exactly N shift_o and N sample_o pulses, never in the same cycle.
- bit_idx_o:
  - Increments in the cycle after each sample_o.
  - Saturates at N-1.
  - Cleared in IDLE.
- HOLD: H cycles with sclk_o at idle level, then IDLE. done_o pulses in the first IDLE cycle.
- spiswai_i=1 while busy:
  - The counter, FSM, sclk_o and bit_idx_o hold.
  - Strobes are forced low.
  - Resume continues exactly where the frame stopped.
  - spiswai_i in IDLE has no effect.
- abort_i while busy:
  - Next cycle: IDLE, sclk_o=cpol, busy_o=0, no done_o, and no strobes from that edge on.
  - abort_i takes precedence over spiswai_i.
- Configuration inputs that change while busy are ignored until the next start.
- start_i while busy is ignored; it is not queued.

## Timing
- Reset values (PRESET_n low at a PCLK edge):
  - FSM in IDLE; counters 0.
  - sclk_o = cpol_i.
  - shift_o, sample_o, busy_o and done_o = 0.
  - bit_idx_o = 0.
- Reset mid-frame is the same as abort but with reset values.
- All outputs except divisor_o are registered.
- Strobes are high in the same cycle as the sclk_o edge they belong to.
- start_i sampled at edge t:
  - busy_o = 1 from cycle t+1.
  - First sclk_o edge at t+1+H; subsequent edges every H cycles.
  - busy_o stays high for exactly (2N+1)·H cycles.
  - done_o is high in the first cycle with busy_o = 0.
- start_i in the same cycle as the done_o pulse is accepted. This gives back-to-back frames with one idle cycle between them.
- The counter wraps from H-1 to 0; there is no terminal overshoot.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE/SETUP/RUN/HOLD),
  - the mode encoding {cpol,cpha},
  - the divisor and half-period functions,
  - the width constants.
- One sub-module, spi_half_period_counter:
  - loadable H and enable/freeze inputs,
  - clears on restart,
  - emits a terminal tick at count H-1.
- The FSM, edge counter and strobe decode live in spi_sclk_engine.

## Test plan
- Reset with cpol_i=1: sclk_o=1 and all strobes, busy_o and done_o at 0. Then cpol_i=0 in IDLE gives sclk_o=0 one cycle later.
- Mode 0, sppr=0, spr=0 (H=1), frame_len=7:
  - 16 edges.
  - 8 shift_o pulses, the first in the first SETUP cycle.
  - 8 sample_o pulses, on rising edges.
  - busy_o high 17 cycles, then one done_o pulse.
- Mode 3, sppr=2, spr=1 (H=6, divisor_o=12), frame_len=15:
  - shift_o on falling edges, sample_o on rising edges.
  - busy_o high 198 cycles.
  - bit_idx_o ends at 15.
- Mode 1, H=2: spiswai_i high for 10 cycles mid-frame. sclk_o and bit_idx_o are frozen and there are no strobes. The frame completes 10 cycles later than nominal.
- Mode 2, abort_i after the 3rd sample: next cycle busy_o=0 and sclk_o=1, with no done_o. A following start_i runs a full frame correctly.
- start_i held continuously in mode 0 with H=1, frame_len=3: consecutive frames separated by exactly one done_o cycle. A second start_i while busy has no effect.
